// File: rtl/clock_time_setter.sv
// Time-setting front end for the BCD clockwork: capture, per-field up/down edit, timed write-back.
// Optional edit-abandon timeout is enabled by defining SETTER_TIMEOUT_EN.
module clock_time_setter #(
  parameter int OW_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] time_current,
  input  logic        btn_edit,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [19:0] time_in,
  output logic        time_ow,
  output logic        editing,
  output logic [1:0]  field_sel
);

  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, APPLY} state_t;

  localparam int OW_W = (OW_CYCLES > 1) ? $clog2(OW_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [19:0]     time_q, time_d;
  logic [OW_W-1:0] ow_cnt_q, ow_cnt_d;
  logic            in_edit;
  logic            step_en;
  logic            timeout_hit;
  logic [5:0]      hour_step;
  logic [6:0]      min_step, sec_step;

  // One BCD step of a field; anything non-BCD or out of range collapses to 00.
  function automatic logic [6:0] step_field(input logic [6:0] v, input logic is_hours,
                                            input logic up);
    logic [2:0] tens;
    logic [3:0] ones;
    logic [2:0] max_tens;
    logic [3:0] max_ones;
    logic       valid;
    logic [6:0] r;
    tens     = v[6:4];
    ones     = v[3:0];
    max_tens = is_hours ? 3'd2 : 3'd5;
    max_ones = is_hours ? 4'd3 : 4'd9;
    valid    = (ones <= 4'd9) &&
               ((tens < max_tens) || ((tens == max_tens) && (ones <= max_ones)));
    r = '0;
    if (!valid) begin
      r = '0;
    end else if (up) begin
      if ((tens == max_tens) && (ones == max_ones)) r = '0;
      else if (ones == 4'd9)                         r = {tens + 3'd1, 4'd0};
      else                                           r = {tens, ones + 4'd1};
    end else begin
      if ((tens == 3'd0) && (ones == 4'd0)) r = {max_tens, max_ones};
      else if (ones == 4'd0)                r = {tens - 3'd1, 4'd9};
      else                                  r = {tens, ones - 4'd1};
    end
    return r;
  endfunction

  assign in_edit   = (state_q == EDIT_H) || (state_q == EDIT_M) || (state_q == EDIT_S);
  assign step_en   = btn_up ^ btn_down;
  assign hour_step = 6'(step_field({1'b0, time_q[19:14]}, 1'b1, btn_up));
  assign min_step  = step_field(time_q[13:7], 1'b0, btn_up);
  assign sec_step  = step_field(time_q[6:0], 1'b0, btn_up);

`ifdef SETTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            any_btn;

  assign any_btn     = btn_edit | btn_up | btn_down;
  assign timeout_hit = in_edit && !any_btn && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (in_edit && !any_btn) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  // No timeout: an edit is never abandoned.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    ow_cnt_d = ow_cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_edit) begin
          time_d  = time_current;
          state_d = EDIT_H;
        end
      end
      EDIT_H: begin
        if (btn_edit)         state_d = EDIT_M;
        else if (timeout_hit) state_d = IDLE;
        else if (step_en)     time_d[19:14] = hour_step;
      end
      EDIT_M: begin
        if (btn_edit)         state_d = EDIT_S;
        else if (timeout_hit) state_d = IDLE;
        else if (step_en)     time_d[13:7] = min_step;
      end
      EDIT_S: begin
        if (btn_edit) begin
          state_d  = APPLY;
          ow_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end else if (step_en) begin
          time_d[6:0] = sec_step;
        end
      end
      APPLY: begin
        if (ow_cnt_q == OW_W'(OW_CYCLES - 1)) state_d = IDLE;
        else                                  ow_cnt_d = ow_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      time_q   <= '0;
      ow_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      ow_cnt_q <= ow_cnt_d;
    end
  end

  assign time_in = time_q;
  assign time_ow = (state_q == APPLY);
  assign editing = in_edit;

  always_comb begin
    field_sel = 2'd0;
    case (state_q)
      EDIT_H:  field_sel = 2'd1;
      EDIT_M:  field_sel = 2'd2;
      EDIT_S:  field_sel = 2'd3;
      default: field_sel = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Scoreboard bench for clock_time_setter: driver queues expected outputs, monitor checks them.
module tb_clock_time_setter;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] time_current;
  logic        btn_edit, btn_up, btn_down;
  logic [19:0] time_in;
  logic        time_ow, editing;
  logic [1:0]  field_sel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] v;
  } exp_t;

  exp_t        expq[$];
  logic [19:0] owq[$];

  clock_time_setter #(.OW_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .time_current(time_current),
    .btn_edit(btn_edit), .btn_up(btn_up), .btn_down(btn_down),
    .time_in(time_in), .time_ow(time_ow), .editing(editing), .field_sel(field_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    logic [1:0] ht;
    logic [3:0] ho;
    logic [2:0] mt, st;
    logic [3:0] mo, so;
    ht = 2'(h / 10); ho = 4'(h % 10);
    mt = 3'(m / 10); mo = 4'(m % 10);
    st = 3'(s / 10); so = 4'(s % 10);
    return {ht, ho, mt, mo, st, so};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: expected output words per cycle, plus one queued time_in per time_ow cycle.
  always @(posedge clk) begin
    #3;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      exp_t e;
      e = expq.pop_front();
      chk(e.name, {8'h0, time_in, time_ow, editing, field_sel}, {8'h0, e.v});
    end
    if (time_ow === 1'b1) begin
      if (owq.size() == 0) chk("ow_unexpected", 32'd1, 32'd0);
      else                 chk("ow_time_in", {12'h0, time_in}, {12'h0, owq.pop_front()});
    end
  end

  task automatic step(input string name, input logic e, input logic u, input logic d,
                      input logic [19:0] tin, input logic ow, input logic ed,
                      input logic [1:0] fs);
    exp_t x;
    btn_edit = e; btn_up = u; btn_down = d;
    x.cyc = cyc + 1; x.name = name; x.v = {tin, ow, ed, fs};
    expq.push_back(x);
    if (ow) owq.push_back(tin);
    @(negedge clk);
    btn_edit = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic capture(input string name, input logic [19:0] t);
    time_current = t;
    step(name, 1'b1, 1'b0, 1'b0, t, 1'b0, 1'b1, 2'd1);
  endtask

  // Enter APPLY from EDIT_S; buttons pressed during APPLY must be ignored.
  task automatic apply(input logic [19:0] t);
    step("apply_c1",   1'b1, 1'b0, 1'b0, t, 1'b1, 1'b0, 2'd0);
    step("apply_c2",   1'b0, 1'b1, 1'b0, t, 1'b1, 1'b0, 2'd0);
    step("apply_c3",   1'b1, 1'b0, 1'b0, t, 1'b1, 1'b0, 2'd0);
    step("apply_c4",   1'b0, 1'b0, 1'b1, t, 1'b1, 1'b0, 2'd0);
    step("apply_done", 1'b1, 1'b0, 1'b0, t, 1'b0, 1'b0, 2'd0);
    step("idle_hold",  1'b0, 1'b0, 1'b0, t, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; btn_edit = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    time_current = bcd(12, 34, 56);
    @(negedge clk);
    chk("rst_time_in", {12'h0, time_in}, 32'h0);
    chk("rst_time_ow", {31'h0, time_ow}, 32'h0);
    chk("rst_editing", {31'h0, editing}, 32'h0);
    chk("rst_field",   {30'h0, field_sel}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step("idle_up_ignored", 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 2'd0);
    capture("capture_123456", bcd(12, 34, 56));
    time_current = bcd(1, 1, 1);
    step("edit_freeze",   1'b0, 1'b0, 1'b0, bcd(12, 34, 56), 1'b0, 1'b1, 2'd1);
    step("h_up",          1'b0, 1'b1, 1'b0, bcd(13, 34, 56), 1'b0, 1'b1, 2'd1);
    step("up_down_both",  1'b0, 1'b1, 1'b1, bcd(13, 34, 56), 1'b0, 1'b1, 2'd1);
    step("edit_beats_up", 1'b1, 1'b1, 1'b0, bcd(13, 34, 56), 1'b0, 1'b1, 2'd2);
    step("m_down",        1'b0, 1'b0, 1'b1, bcd(13, 33, 56), 1'b0, 1'b1, 2'd2);
    step("to_sec",        1'b1, 1'b0, 1'b0, bcd(13, 33, 56), 1'b0, 1'b1, 2'd3);
    step("s_up",          1'b0, 1'b1, 1'b0, bcd(13, 33, 57), 1'b0, 1'b1, 2'd3);
    apply(bcd(13, 33, 57));

    capture("capture_235939", bcd(23, 59, 39));
    step("h_23_up",   1'b0, 1'b1, 1'b0, bcd(0, 59, 39),  1'b0, 1'b1, 2'd1);
    step("h_00_down", 1'b0, 1'b0, 1'b1, bcd(23, 59, 39), 1'b0, 1'b1, 2'd1);
    step("to_min",    1'b1, 1'b0, 1'b0, bcd(23, 59, 39), 1'b0, 1'b1, 2'd2);
    step("m_59_up",   1'b0, 1'b1, 1'b0, bcd(23, 0, 39),  1'b0, 1'b1, 2'd2);
    step("m_00_down", 1'b0, 1'b0, 1'b1, bcd(23, 59, 39), 1'b0, 1'b1, 2'd2);
    step("to_sec",    1'b1, 1'b0, 1'b0, bcd(23, 59, 39), 1'b0, 1'b1, 2'd3);
    step("s_39_up",   1'b0, 1'b1, 1'b0, bcd(23, 59, 40), 1'b0, 1'b1, 2'd3);
    apply(bcd(23, 59, 40));

    capture("capture_094500", bcd(9, 45, 0));
    step("h_09_up",   1'b0, 1'b1, 1'b0, bcd(10, 45, 0), 1'b0, 1'b1, 2'd1);
    step("h_10_down", 1'b0, 1'b0, 1'b1, bcd(9, 45, 0),  1'b0, 1'b1, 2'd1);
    step("h_09_down", 1'b0, 1'b0, 1'b1, bcd(8, 45, 0),  1'b0, 1'b1, 2'd1);
    step("h_08_down", 1'b0, 1'b0, 1'b1, bcd(7, 45, 0),  1'b0, 1'b1, 2'd1);
    step("to_min",    1'b1, 1'b0, 1'b0, bcd(7, 45, 0),  1'b0, 1'b1, 2'd2);
    step("to_sec",    1'b1, 1'b0, 1'b0, bcd(7, 45, 0),  1'b0, 1'b1, 2'd3);
    apply(bcd(7, 45, 0));

    capture("capture_200059", bcd(20, 0, 59));
    step("h_20_down", 1'b0, 1'b0, 1'b1, bcd(19, 0, 59),  1'b0, 1'b1, 2'd1);
    step("to_min",    1'b1, 1'b0, 1'b0, bcd(19, 0, 59),  1'b0, 1'b1, 2'd2);
    step("m_00_down", 1'b0, 1'b0, 1'b1, bcd(19, 59, 59), 1'b0, 1'b1, 2'd2);
    step("m_59_up",   1'b0, 1'b1, 1'b0, bcd(19, 0, 59),  1'b0, 1'b1, 2'd2);
    step("to_sec",    1'b1, 1'b0, 1'b0, bcd(19, 0, 59),  1'b0, 1'b1, 2'd3);
    step("s_59_up",   1'b0, 1'b1, 1'b0, bcd(19, 0, 0),   1'b0, 1'b1, 2'd3);
    step("apply_r_c1", 1'b1, 1'b0, 1'b0, bcd(19, 0, 0), 1'b1, 1'b0, 2'd0);
    step("apply_r_c2", 1'b0, 1'b0, 1'b0, bcd(19, 0, 0), 1'b1, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    chk("midapply_rst_time_ow", {31'h0, time_ow}, 32'h0);
    chk("midapply_rst_time_in", {12'h0, time_in}, 32'h0);
    chk("midapply_rst_field",   {30'h0, field_sel}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_idle", 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 2'd0);

    capture("capture_invalid", {6'h2A, 7'h61, 7'h7F});
    step("h_2A_up",   1'b0, 1'b1, 1'b0, {6'h00, 7'h61, 7'h7F}, 1'b0, 1'b1, 2'd1);
    step("to_min",    1'b1, 1'b0, 1'b0, {6'h00, 7'h61, 7'h7F}, 1'b0, 1'b1, 2'd2);
    step("m_61_down", 1'b0, 1'b0, 1'b1, {6'h00, 7'h00, 7'h7F}, 1'b0, 1'b1, 2'd2);
    step("to_sec",    1'b1, 1'b0, 1'b0, {6'h00, 7'h00, 7'h7F}, 1'b0, 1'b1, 2'd3);
    step("s_7F_up",   1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b1, 2'd3);
    apply(20'h0);

    capture("capture_010203", bcd(1, 2, 3));
    step("to_min", 1'b1, 1'b0, 1'b0, bcd(1, 2, 3), 1'b0, 1'b1, 2'd2);
    for (int k = 1; k <= 20; k++) begin
`ifdef SETTER_TIMEOUT_EN
      if (k < 16) step("timeout_wait", 1'b0, 1'b0, 1'b0, bcd(1, 2, 3), 1'b0, 1'b1, 2'd2);
      else        step("timeout_idle", 1'b0, 1'b0, 1'b0, bcd(1, 2, 3), 1'b0, 1'b0, 2'd0);
`else
      step("no_timeout", 1'b0, 1'b0, 1'b0, bcd(1, 2, 3), 1'b0, 1'b1, 2'd2);
`endif
    end

    @(negedge clk);
    @(negedge clk);
    chk("expq_drained", expq.size(), 32'd0);
    chk("owq_drained",  owq.size(),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
